// File: rtl/req_ack_arbiter.sv
// Round-robin arbiter: N_REQ level req/ack requesters share one single-outstanding resource.
// Latency: req seen in IDLE at t -> res_valid t+1 -> res_done >= t+2 -> ack t+3 (4-cycle min).
// Backpressure: res_done may stall WAIT_DONE indefinitely; optional checks via REQ_ACK_ARBITER_ASSERT_EN.
module req_ack_arbiter #(
    parameter int  N_REQ    = 4,
    parameter int  MAX_WAIT = 16,
    localparam int CNT_W    = $clog2(MAX_WAIT + 1),
    localparam int ID_W     = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] ack,
    output logic             res_valid,
    output logic [ID_W-1:0]  res_id,
    input  logic             res_done,
    output logic             busy,
    output logic [N_REQ-1:0] starve
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        ACK
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

    state_t           state;
    state_t           state_nxt;
    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  pick;
    logic             found;
    logic [ID_W:0]    sum;
    logic [N_REQ-1:0] ack_nxt;
    logic             res_valid_nxt;
    logic [ID_W-1:0]  res_id_nxt;
    logic [CNT_W-1:0] wait_cnt [N_REQ];

    // Search upward from ptr+1 with wrap; ptr holds the last served requester.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        sum   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            sum = {1'b0, ptr} + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(N_REQ)) begin
                sum = sum - (ID_W+1)'(N_REQ);
            end
            if (!found && req[sum[ID_W-1:0]]) begin
                found = 1'b1;
                pick  = sum[ID_W-1:0];
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        ack_nxt       = '0;
        res_valid_nxt = 1'b0;
        res_id_nxt    = res_id;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt     = ISSUE;
                    res_valid_nxt = 1'b1;
                    res_id_nxt    = pick;
                end
            end
            ISSUE: begin
                state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (res_done) begin
                    state_nxt       = ACK;
                    ack_nxt[res_id] = 1'b1;
                end
            end
            ACK: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ack       <= '0;
            res_valid <= 1'b0;
            res_id    <= '0;
            ptr       <= ID_W'(N_REQ - 1);
        end else begin
            state     <= state_nxt;
            ack       <= ack_nxt;
            res_valid <= res_valid_nxt;
            res_id    <= res_id_nxt;
            if (state == ACK) begin
                ptr <= res_id;
            end
        end
    end

    assign busy = (state != IDLE);

    // An ack in the same cycle as the final increment clears the counter and suppresses starve.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                wait_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!req[i] || ack[i]) begin
                    wait_cnt[i] <= '0;
                end else if (wait_cnt[i] != MAX_CNT) begin
                    wait_cnt[i] <= wait_cnt[i] + 1'b1;
                    if (wait_cnt[i] == MAX_CNT - 1'b1) begin
                        starve[i] <= 1'b1;
                    end
                end
            end
        end
    end

`ifdef REQ_ACK_ARBITER_ASSERT_EN
    for (genvar g = 0; g < N_REQ; g++) begin : g_live
        a_req_acked: assert property (@(posedge clk) disable iff (rst)
            $rose(req[g]) |-> ##[1:$] ack[g])
            else $error("req_ack_arbiter: requester %0d not acked", g);
    end

    a_ack_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(ack))
        else $error("req_ack_arbiter: ack not onehot0, requester %0d", res_id);

    a_valid_busy: assert property (@(posedge clk) disable iff (rst) res_valid |-> busy)
        else $error("req_ack_arbiter: res_valid while idle, requester %0d", res_id);

    a_valid_pulse: assert property (@(posedge clk) disable iff (rst) res_valid |=> !res_valid)
        else $error("req_ack_arbiter: res_valid longer than one cycle, requester %0d", res_id);
`endif

endmodule
